// File: rtl/fp_pkg.sv
// Shared definitions for the single-precision adder datapath: field widths,
// the unpacked operand record and the operand unpack helper.
package fp_pkg;

    localparam int EXP_WIDTH    = 8;
    localparam int MANT_WIDTH   = 23;
    localparam int SIGNIF_WIDTH = 25;
    localparam int SHIFT_WIDTH  = 5;
    localparam int BIAS         = 127;
    localparam int ALIGN_SAT    = 25;
    localparam int MAG_WIDTH    = MANT_WIDTH + 1;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [MAG_WIDTH-1:0] mag;
    } fp_unpacked_t;

    // Denormals get effective exponent 1 and no hidden bit; flip folds op_sub into B's sign.
    function automatic fp_unpacked_t fp_unpack(input logic [31:0] x, input logic flip);
        fp_unpacked_t u;
        logic [EXP_WIDTH-1:0] e;
        e      = x[MANT_WIDTH +: EXP_WIDTH];
        u.sign = x[31] ^ flip;
        u.exp  = (e == '0) ? EXP_WIDTH'(1) : e;
        u.mag  = {(e != '0), x[MANT_WIDTH-1:0]};
        return u;
    endfunction

endpackage

// File: rtl/fp_align_shifter.sv
// Combinational alignment shifter: right-shifts the smaller magnitude and
// reports whether any set bit fell off the bottom.
module fp_align_shifter
    import fp_pkg::*;
(
    input  logic [MAG_WIDTH-1:0]   din,
    input  logic [SHIFT_WIDTH-1:0] shamt,
    output logic [MAG_WIDTH-1:0]   dout,
    output logic                   sticky
);

    localparam int EXT = 2 ** SHIFT_WIDTH;

    logic [MAG_WIDTH+EXT-1:0] wide;

    // The extension field is wide enough that no shift count can lose bits past it.
    always_comb begin
        wide   = {din, EXT'(0)} >> shamt;
        dout   = wide[MAG_WIDTH+EXT-1:EXT];
        sticky = |wide[EXT-1:0];
    end

endmodule

// File: rtl/fp_align_add.sv
// Two-stage align-and-add front end of the single-precision adder/subtractor,
// with valid/ready flow control and an unnormalized significand output.
module fp_align_add #(
    parameter int EXP_WIDTH    = fp_pkg::EXP_WIDTH,
    parameter int MANT_WIDTH   = fp_pkg::MANT_WIDTH,
    parameter int SIGNIF_WIDTH = fp_pkg::SIGNIF_WIDTH,
    parameter int SHIFT_WIDTH  = fp_pkg::SHIFT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             a,
    input  logic [31:0]             b,
    input  logic                    op_sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [SIGNIF_WIDTH-1:0] significand,
    output logic [EXP_WIDTH-1:0]    exponent_a,
    output logic                    sign,
    output logic                    sticky,
    output logic                    out_zero
);

    localparam int MAG_W = MANT_WIDTH + 1;

    function automatic logic [SHIFT_WIDTH-1:0] sat_shift(input logic [EXP_WIDTH-1:0] d);
        return (d >= EXP_WIDTH'(fp_pkg::ALIGN_SAT)) ? SHIFT_WIDTH'(fp_pkg::ALIGN_SAT)
                                                     : d[SHIFT_WIDTH-1:0];
    endfunction

    fp_pkg::fp_unpacked_t ua, ub, op_l, op_s;
    logic a_is_l;
    logic s2_load, s1_load;

    logic                    s1_valid_q, s1_valid_d;
    logic [MAG_W-1:0]        s1_mag_l_q, s1_mag_l_d;
    logic [MAG_W-1:0]        s1_mag_s_q, s1_mag_s_d;
    logic [EXP_WIDTH-1:0]    s1_exp_l_q, s1_exp_l_d;
    logic                    s1_sign_l_q, s1_sign_l_d;
    logic [SHIFT_WIDTH-1:0]  s1_shamt_q, s1_shamt_d;
    logic                    s1_sub_q, s1_sub_d;

    logic                    s2_valid_q, s2_valid_d;
    logic [SIGNIF_WIDTH-1:0] s2_sig_q, s2_sig_d;
    logic [EXP_WIDTH-1:0]    s2_exp_q, s2_exp_d;
    logic                    s2_sign_q, s2_sign_d;
    logic                    s2_sticky_q, s2_sticky_d;
    logic                    s2_zero_q, s2_zero_d;

    logic [MAG_W-1:0]        aligned_s;
    logic                    shift_sticky;
    logic [SIGNIF_WIDTH-1:0] sum;

    assign s2_load  = ~s2_valid_q | out_ready;
    assign s1_load  = ~s1_valid_q | s2_load;
    assign in_ready = s1_load;

    // Stage 1: unpack, order by magnitude, compute saturated shift.
    always_comb begin
        ua     = fp_pkg::fp_unpack(a, 1'b0);
        ub     = fp_pkg::fp_unpack(b, op_sub);
        a_is_l = {ua.exp, ua.mag} >= {ub.exp, ub.mag};
        op_l   = a_is_l ? ua : ub;
        op_s   = a_is_l ? ub : ua;

        s1_valid_d  = s1_valid_q;
        s1_mag_l_d  = s1_mag_l_q;
        s1_mag_s_d  = s1_mag_s_q;
        s1_exp_l_d  = s1_exp_l_q;
        s1_sign_l_d = s1_sign_l_q;
        s1_shamt_d  = s1_shamt_q;
        s1_sub_d    = s1_sub_q;
        if (s1_load) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_mag_l_d  = op_l.mag;
                s1_mag_s_d  = op_s.mag;
                s1_exp_l_d  = op_l.exp;
                s1_sign_l_d = op_l.sign;
                s1_shamt_d  = sat_shift(op_l.exp - op_s.exp);
                s1_sub_d    = ua.sign ^ ub.sign;
            end
        end
    end

    fp_align_shifter u_shifter (
        .din    (s1_mag_s_q),
        .shamt  (s1_shamt_q),
        .dout   (aligned_s),
        .sticky (shift_sticky)
    );

    // Stage 2: align and add/subtract; L >= S keeps the difference non-negative.
    always_comb begin
        sum = s1_sub_q ? ({1'b0, s1_mag_l_q} - {1'b0, aligned_s})
                       : ({1'b0, s1_mag_l_q} + {1'b0, aligned_s});

        s2_valid_d  = s2_valid_q;
        s2_sig_d    = s2_sig_q;
        s2_exp_d    = s2_exp_q;
        s2_sign_d   = s2_sign_q;
        s2_sticky_d = s2_sticky_q;
        s2_zero_d   = s2_zero_q;
        if (s2_load) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_sig_d    = sum;
                s2_exp_d    = s1_exp_l_q;
                s2_sign_d   = s1_sign_l_q & ~(s1_sub_q & (sum == '0));
                s2_sticky_d = shift_sticky;
                s2_zero_d   = (sum == '0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_mag_l_q  <= '0;
            s1_mag_s_q  <= '0;
            s1_exp_l_q  <= '0;
            s1_sign_l_q <= 1'b0;
            s1_shamt_q  <= '0;
            s1_sub_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sig_q    <= '0;
            s2_exp_q    <= '0;
            s2_sign_q   <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_zero_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_mag_l_q  <= s1_mag_l_d;
            s1_mag_s_q  <= s1_mag_s_d;
            s1_exp_l_q  <= s1_exp_l_d;
            s1_sign_l_q <= s1_sign_l_d;
            s1_shamt_q  <= s1_shamt_d;
            s1_sub_q    <= s1_sub_d;
            s2_valid_q  <= s2_valid_d;
            s2_sig_q    <= s2_sig_d;
            s2_exp_q    <= s2_exp_d;
            s2_sign_q   <= s2_sign_d;
            s2_sticky_q <= s2_sticky_d;
            s2_zero_q   <= s2_zero_d;
        end
    end

    assign out_valid   = s2_valid_q;
    assign significand = s2_sig_q;
    assign exponent_a  = s2_exp_q;
    assign sign        = s2_sign_q;
    assign sticky      = s2_sticky_q;
    assign out_zero    = s2_zero_q;

endmodule

// File: tb/tb_fp_align_add.sv
// Bench for fp_align_add: directed vectors, backpressure, mid-run reset and
// random traffic scored against an integer-arithmetic reference.
module tb_fp_align_add;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [24:0] significand;
    logic [7:0]  exponent_a;
    logic        sign;
    logic        sticky;
    logic        out_zero;

    fp_align_add dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op_sub      (op_sub),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .significand (significand),
        .exponent_a  (exponent_a),
        .sign        (sign),
        .sticky      (sticky),
        .out_zero    (out_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [24:0] sig;
        logic [7:0]  ex;
        logic        sg;
        logic        st;
        logic        z;
        int          t;
    } exp_t;

    exp_t q[$];
    exp_t dir_e;
    logic nxt_dir = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic last_acc;
    logic saw_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference computed directly from operand values with wide integers.
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        exp_t   e;
        longint ex_, ey_, mx, my, el, es, ml, ms, al, res, diff;
        logic   sx, sy, sl, eff_sub, x_big, lost;
        ex_ = (x[30:23] == 0) ? 1 : longint'(x[30:23]);
        ey_ = (y[30:23] == 0) ? 1 : longint'(y[30:23]);
        mx  = longint'({(x[30:23] != 0), x[22:0]});
        my  = longint'({(y[30:23] != 0), y[22:0]});
        sx  = x[31];
        sy  = y[31] ^ sub;
        eff_sub = sx ^ sy;
        x_big = (ex_ > ey_) || (ex_ == ey_ && mx >= my);
        el = x_big ? ex_ : ey_;  es = x_big ? ey_ : ex_;
        ml = x_big ? mx : my;    ms = x_big ? my : mx;
        sl = x_big ? sx : sy;
        diff = el - es;
        if (diff >= 40) begin
            al = 0;
            lost = (ms != 0);
        end else begin
            al = ms >> diff;
            lost = ((ms & ((64'sd1 <<< diff) - 1)) != 0);
        end
        res = eff_sub ? ml - al : ml + al;
        e.sig = res[24:0];
        e.ex  = el[7:0];
        e.sg  = (eff_sub && res == 0) ? 1'b0 : sl;
        e.st  = lost;
        e.z   = (res == 0);
        e.t   = 0;
        return e;
    endfunction

    // One clock: check handshake/outputs before the edge, score, advance, check holds.
    task automatic step();
        logic        hold;
        logic [24:0] h_sig;
        logic [7:0]  h_ex;
        logic        h_sg, h_st, h_z;
        logic [31:0] sa, sb;
        logic        so;
        exp_t        e;
        #1;
        chk("in_ready", 32'(in_ready), 32'((q.size() < 2) || out_ready));
        chk("out_valid", 32'(out_valid), 32'((q.size() > 0) && (cyc >= q[0].t + 1)));
        if (in_valid && !in_ready) saw_stall = 1'b1;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'(out_valid), 32'd0);
            end else begin
                e = q.pop_front();
                chk("significand", 32'(significand), 32'(e.sig));
                chk("exponent_a", 32'(exponent_a), 32'(e.ex));
                chk("sign", 32'(sign), 32'(e.sg));
                chk("sticky", 32'(sticky), 32'(e.st));
                chk("out_zero", 32'(out_zero), 32'(e.z));
            end
        end
        hold = out_valid && !out_ready;
        h_sig = significand; h_ex = exponent_a; h_sg = sign; h_st = sticky; h_z = out_zero;
        last_acc = in_valid && in_ready;
        sa = a; sb = b; so = op_sub;
        @(posedge clk);
        cyc++;
        if (last_acc) begin
            e = nxt_dir ? dir_e : model(sa, sb, so);
            e.t = cyc;
            q.push_back(e);
        end
        #1;
        if (hold) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_sig", 32'(significand), 32'(h_sig));
            chk("hold_exp", 32'(exponent_a), 32'(h_ex));
            chk("hold_flags", {29'd0, sign, sticky, out_zero}, {29'd0, h_sg, h_st, h_z});
        end
    endtask

    task automatic send_dir(input logic [31:0] x, input logic [31:0] y, input logic sub,
                            input logic [24:0] sig, input logic [7:0] ex,
                            input logic sg, input logic st, input logic z);
        a = x; b = y; op_sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        dir_e.sig = sig; dir_e.ex = ex; dir_e.sg = sg; dir_e.st = st; dir_e.z = z; dir_e.t = 0;
        nxt_dir = 1'b1;
        step();
        nxt_dir = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic rand_ops();
        logic [7:0] ea, eb;
        int         off;
        ea = 8'($urandom_range(0, 255));
        case ($urandom_range(0, 3))
            0: eb = ea;
            1, 2: begin
                off = int'($urandom_range(0, 60)) - 30;
                eb = 8'((int'(ea) + off < 0) ? 0 : (int'(ea) + off > 255) ? 255 : int'(ea) + off);
            end
            default: eb = 8'($urandom_range(0, 255));
        endcase
        a = {1'($urandom), ea, 23'($urandom)};
        b = {1'($urandom), eb, 23'($urandom)};
        if ($urandom_range(0, 7) == 0) b[30:0] = a[30:0];
        if ($urandom_range(0, 7) == 0) a[30:0] = 31'($urandom_range(0, 8388607));
        op_sub = 1'($urandom);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk("drained", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int sent;
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sig", 32'(significand), 32'd0);
        chk("rst_exp", 32'(exponent_a), 32'd0);
        chk("rst_flags", {29'd0, sign, sticky, out_zero}, 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        send_dir(32'h3F800000, 32'h3F800000, 1'b0, 25'h1000000, 8'h7F, 1'b0, 1'b0, 1'b0);
        send_dir(32'h3FC00000, 32'h3F800000, 1'b1, 25'h0400000, 8'h7F, 1'b0, 1'b0, 1'b0);
        send_dir(32'h3F800000, 32'h3F800000, 1'b1, 25'h0000000, 8'h7F, 1'b0, 1'b0, 1'b1);
        send_dir(32'h3F800000, 32'h30800000, 1'b0, 25'h0800000, 8'h7F, 1'b0, 1'b1, 1'b0);
        send_dir(32'h3F800000, 32'hBFC00000, 1'b0, 25'h0400000, 8'h7F, 1'b1, 1'b0, 1'b0);
        drain();

        // Four back-to-back inputs with a three-cycle output stall from cycle 2
        sent = 0;
        saw_stall = 1'b0;
        for (int i = 0; i < 30 && (sent < 4 || q.size() > 0); i++) begin
            rand_ops();
            in_valid = (sent < 4);
            out_ready = !(i >= 2 && i < 5);
            step();
            if (last_acc) sent++;
        end
        chk("stream_sent", 32'(sent), 32'd4);
        chk("stream_stall_seen", 32'(saw_stall), 32'd1);
        drain();

        // Reset while both stages hold data
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            in_valid = 1'b1;
            step();
        end
        chk("midrst_full", 32'(q.size()), 32'd2);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_sig", 32'(significand), 32'd0);
        chk("midrst_exp", 32'(exponent_a), 32'd0);
        chk("midrst_flags", {29'd0, sign, sticky, out_zero}, 32'd0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_dir(32'h40000000, 32'h3F800000, 1'b0, 25'h0C00000, 8'h80, 1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("post_rst_delivered", 32'(q.size()), 32'd0);

        // Random traffic with random backpressure
        sent = 0;
        for (int i = 0; i < 400 && sent < 80; i++) begin
            rand_ops();
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
            if (last_acc) sent++;
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_align_add.md
# fp_align_add

Two-stage pipelined align-and-add front end of the 32-bit IEEE-754 floating-point adder/subtractor. It unpacks two single-precision operands, orders them by magnitude, right-aligns the smaller significand, then adds or subtracts. It hands a 25-bit unnormalized significand plus the larger operand's exponent directly to the normalization stage (priority encoder). A valid/ready handshake on both sides lets the normalization/round path apply backpressure.

## Interface
- EXP_WIDTH, default 8: exponent field width.
- MANT_WIDTH, default 23: stored fraction width.
- SIGNIF_WIDTH, default 25: output significand width (carry + hidden + fraction).
- SHIFT_WIDTH, default 5: alignment shift count width.
- clk  in  1  single clock, all flops rising-edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands and op valid this cycle.
- in_ready  out  1  block accepts operands this cycle.
- a  in  32  operand A, IEEE-754 single.
- b  in  32  operand B, IEEE-754 single.
- op_sub  in  1  1 = A − B, 0 = A + B.
- out_valid  out  1  result fields valid.
- out_ready  in  1  downstream accepts result.
- significand  out  SIGNIF_WIDTH  unnormalized magnitude result, bit 24 = carry.
- exponent_a  out  EXP_WIDTH  exponent of larger-magnitude operand (biased, denormal reads as 1).
- sign  out  1  result sign.
- sticky  out  1  OR of all bits shifted out during alignment.
- out_zero  out  1  significand is all zeros.

## Operation
- Unpack: hidden bit = (exp != 0); effective exponent = exp, or 1 when exp == 0. 24-bit magnitude = {hidden, fraction}.
- Effective B sign = b[31] XOR op_sub. Effective operation is subtract when the A sign differs from the effective B sign.
- Stage 1 (S1): compare {eff_exp, mag} of A and B. The larger is L, the smaller is S; on a tie, L = A. Compute diff = exp_L − exp_S. Saturate the shift at 25: any diff ≥ 25 shifts S fully out. Register L mag/exp/sign, S mag, the shift count, and the effective-op bit.
- Stage 2 (S2): shift S right by the count. Sticky = OR of the discarded bits; sticky = 1 when saturated and S mag != 0. Output significand = {1'b0, mag_L} + {1'b0, aligned_S} for add, or {1'b0, mag_L} − {1'b0, aligned_S} for subtract. Sticky does not feed into the arithmetic. Subtract is always non-negative because L ≥ S.
- sign = sign_L, except an exact-zero subtract result forces sign = 0.
- out_zero = (significand == 0).
- NaN/Inf are not handled here. They pass as ordinary exponent 0xFF values, and detection belongs to the wrapper.

## Timing
- Latency 2 cycles from accepted input (in_valid & in_ready) to out_valid. Throughput is 1 per cycle when out_ready stays high.
- Stage registers S1 and S2 each carry a valid bit.
  - S2 loads when ~s2_valid | out_ready.
  - S1 loads when ~s1_valid | S2 loads.
  - in_ready = ~s1_valid | S2 loads.
- The output holds stable while out_valid & ~out_ready. No result is dropped or duplicated.
- Simultaneous accept and drain in the same cycle is allowed in every stage.
- Reset (rst_n low, any time, including mid-operation) clears s1_valid, s2_valid and all data registers to 0 asynchronously. After reset: out_valid 0, significand 0, exponent_a 0, sign 0, sticky 0, out_zero 0. in_ready is 1 in the first cycle after reset release.

## Structure
- Shared package fp_pkg: EXP_WIDTH, MANT_WIDTH, SIGNIF_WIDTH, SHIFT_WIDTH, BIAS = 127, an unpacked-operand typedef {sign, exp, mag}, and the alignment saturation constant 25.
- One sub-module, fp_align_shifter: combinational right shifter (24-bit input, 5-bit count) producing the aligned value and sticky. It is instantiated in S2.
- All pipeline state stays in fp_align_add.

## Test plan
- a=0x3F800000, b=0x3F800000, op_sub=0 → after 2 cycles: significand=0x1000000, exponent_a=0x7F, sign=0, sticky=0.
- a=0x3FC00000, b=0x3F800000, op_sub=1 → significand=0x0400000, exponent_a=0x7F, sign=0, out_zero=0.
- a=0x3F800000, b=0x3F800000, op_sub=1 → significand=0, out_zero=1, sign=0.
- a=0x3F800000, b=0x30800000 (diff 30), op_sub=0 → significand=0x0800000, sticky=1. Also a=0x3F800000, b=0xBFC00000, op_sub=0 → L = B, sign=1, significand=0x0400000.
- Stream 4 back-to-back inputs with out_ready low for 3 cycles starting at cycle 2 → in_ready low while both stages are full, all 4 results delivered in order, each held stable until accepted.
- Assert rst_n low while both stages are valid → out_valid drops immediately and all outputs read 0. After release, the next input emerges after exactly 2 cycles.
